// File: rtl/dir_pkg.sv
// Encodings shared by the home-node directory controller: directory state,
// request and message types, and the control FSM states.
package dir_pkg;

  typedef enum logic [1:0] {
    DIR_SHARED   = 2'd0,
    DIR_UNCACHED = 2'd1,
    DIR_EXCL     = 2'd2
  } dir_state_e;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_RM   = 2'd1,
    REQ_WM   = 2'd2,
    REQ_WB   = 2'd3
  } req_type_e;

  typedef enum logic [1:0] {
    MSG_DVR       = 2'd0,
    MSG_FETCH     = 2'd1,
    MSG_INV       = 2'd2,
    MSG_FETCH_INV = 2'd3
  } msg_type_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INV    = 3'd1,
    ST_FETCH  = 3'd2,
    ST_WAITWB = 3'd3,
    ST_REPLY  = 3'd4
  } fsm_state_e;

endpackage

// File: rtl/sharer_pick.sv
// Combinational search for the lowest set sharer index at or above a start
// index, skipping one excluded processor.
module sharer_pick #(
  parameter int NPROC = 4,
  parameter int PID_W = 2
) (
  input  logic [NPROC-1:0] vec,
  input  logic [PID_W-1:0] exclude,
  input  logic [PID_W:0]   start,
  output logic [PID_W-1:0] idx,
  output logic             found
);

  // Descending scan so the lowest qualifying index is the one left standing.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = NPROC - 1; i >= 0; i--) begin
      if (vec[i] && (i != int'(exclude)) && (i >= int'(start))) begin
        found = 1'b1;
        idx   = PID_W'(i);
      end
    end
  end

endmodule

// File: rtl/directory_controller.sv
// MSI home-node directory for one memory block: accepts RM/WM/WB requests,
// sequences fetch/invalidate/data-reply messages and tracks the sharer set.
module directory_controller
  import dir_pkg::*;
#(
  parameter  int NPROC = 4,
  localparam int PID_W = (NPROC > 2) ? $clog2(NPROC) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_type,
  input  logic [PID_W-1:0] req_pid,
  output logic             msg_valid,
  input  logic             msg_ready,
  output logic [1:0]       msg_type,
  output logic [PID_W-1:0] msg_pid,
  output logic [1:0]       dir_state,
  output logic [NPROC-1:0] sharers,
  output logic             err
);

  fsm_state_e       state_q, state_nxt;
  dir_state_e       dir_q, dir_nxt;
  msg_type_e        mtype_q, mtype_nxt;
  logic [NPROC-1:0] sharers_q, sharers_nxt;
  logic [PID_W-1:0] mpid_q, mpid_nxt;
  logic [PID_W-1:0] cur_pid_q, cur_pid_nxt;
  logic             cur_rm_q, cur_rm_nxt;
  logic             mvalid_q, mvalid_nxt;
  logic             err_q, err_nxt;

  req_type_e        rtype;
  logic [PID_W-1:0] owner;
  logic [PID_W-1:0] pick_excl, pick_idx;
  logic [PID_W:0]   pick_start;
  logic             pick_found;

  assign rtype     = req_type_e'(req_type);
  assign msg_valid = mvalid_q;
  assign msg_type  = mtype_q;
  assign msg_pid   = mpid_q;
  assign dir_state = dir_q;
  assign sharers   = sharers_q;
  assign err       = err_q;

  // Only meaningful in Exclusive, where exactly one sharer bit is set.
  always_comb begin
    owner = '0;
    for (int i = 0; i < NPROC; i++) begin
      if (sharers_q[i]) owner = PID_W'(i);
    end
  end

  // IDLE searches from index 0 for the new requester; INV resumes just past
  // the invalidate that is currently being handed off.
  assign pick_excl  = (state_q == ST_INV) ? cur_pid_q : req_pid;
  assign pick_start = (state_q == ST_INV) ? ((PID_W+1)'(mpid_q) + (PID_W+1)'(1)) : '0;

  sharer_pick #(.NPROC(NPROC), .PID_W(PID_W)) u_pick (
    .vec     (sharers_q),
    .exclude (pick_excl),
    .start   (pick_start),
    .idx     (pick_idx),
    .found   (pick_found)
  );

  always_comb begin
    state_nxt   = state_q;
    dir_nxt     = dir_q;
    sharers_nxt = sharers_q;
    mvalid_nxt  = mvalid_q;
    mtype_nxt   = mtype_q;
    mpid_nxt    = mpid_q;
    cur_pid_nxt = cur_pid_q;
    cur_rm_nxt  = cur_rm_q;
    err_nxt     = 1'b0;
    req_ready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          case (rtype)
            REQ_RM, REQ_WM: begin
              cur_pid_nxt = req_pid;
              cur_rm_nxt  = (rtype == REQ_RM);
              mvalid_nxt  = 1'b1;
              if (dir_q == DIR_EXCL && req_pid != owner) begin
                state_nxt = ST_FETCH;
                mtype_nxt = (rtype == REQ_RM) ? MSG_FETCH : MSG_FETCH_INV;
                mpid_nxt  = owner;
              end else if (dir_q == DIR_SHARED && rtype == REQ_WM && pick_found) begin
                state_nxt = ST_INV;
                mtype_nxt = MSG_INV;
                mpid_nxt  = pick_idx;
              end else begin
                state_nxt = ST_REPLY;
                mtype_nxt = MSG_DVR;
                mpid_nxt  = req_pid;
              end
            end
            REQ_WB: begin
              if (dir_q == DIR_EXCL && req_pid == owner) begin
                dir_nxt     = DIR_UNCACHED;
                sharers_nxt = '0;
              end else begin
                err_nxt = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      ST_INV: begin
        if (msg_ready) begin
          if (pick_found) begin
            mpid_nxt = pick_idx;
          end else begin
            state_nxt = ST_REPLY;
            mtype_nxt = MSG_DVR;
            mpid_nxt  = cur_pid_q;
          end
        end
      end
      ST_FETCH: begin
        if (msg_ready) begin
          state_nxt  = ST_WAITWB;
          mvalid_nxt = 1'b0;
        end
      end
      ST_WAITWB: begin
        req_ready = req_valid && (rtype == REQ_WB) && (req_pid == owner);
        if (req_ready) begin
          state_nxt  = ST_REPLY;
          mvalid_nxt = 1'b1;
          mtype_nxt  = MSG_DVR;
          mpid_nxt   = cur_pid_q;
        end
      end
      ST_REPLY: begin
        // Commit point: read adds the requester to whatever set is recorded
        // (covers the {O,P} case), write leaves the requester sole owner.
        if (msg_ready) begin
          state_nxt  = ST_IDLE;
          mvalid_nxt = 1'b0;
          if (cur_rm_q) begin
            dir_nxt     = DIR_SHARED;
            sharers_nxt = sharers_q | (NPROC'(1) << cur_pid_q);
          end else begin
            dir_nxt     = DIR_EXCL;
            sharers_nxt = NPROC'(1) << cur_pid_q;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_UNCACHED;
      sharers_q <= '0;
      mvalid_q  <= 1'b0;
      mtype_q   <= MSG_DVR;
      mpid_q    <= '0;
      cur_pid_q <= '0;
      cur_rm_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      dir_q     <= dir_nxt;
      sharers_q <= sharers_nxt;
      mvalid_q  <= mvalid_nxt;
      mtype_q   <= mtype_nxt;
      mpid_q    <= mpid_nxt;
      cur_pid_q <= cur_pid_nxt;
      cur_rm_q  <= cur_rm_nxt;
      err_q     <= err_nxt;
    end
  end

endmodule
